// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared FFT stage-controller states and default frame/delay sizes.
package fft_ctrl_pkg;
    localparam int N_DEF = 64;
    localparam int D_DEF = 16;
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;
endpackage

// File: rtl/cu_mod0_1_if.sv
// cu_mod0_1_if: upstream frame/beat inputs and stage-control outputs of one FFT stage.
interface cu_mod0_1_if import fft_ctrl_pkg::*; #(parameter int N = N_DEF);
    localparam int LW = $clog2(N);
    logic alert_in;
    logic valid_in;
    logic bf_en;
    logic valid_out;
    logic [LW-1:0] idx_out;
    logic alert_out;
    logic busy;
    logic err;
    modport master(output alert_in, valid_in, input bf_en, valid_out, idx_out, alert_out, busy, err);
    modport slave(input alert_in, valid_in, output bf_en, valid_out, idx_out, alert_out, busy, err);
endinterface

// File: rtl/cu_mod0_1_cnt.sv
// cnt_en_nb: W-bit up counter with enable, synchronous clear and async active-high reset.
module cnt_en_nb #(parameter int W = 4) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= '0;
        else q_q <= clr_i ? '0 : en_i ? q_q + 1'b1 : q_q;
    assign q_o = q_q;
endmodule

// File: rtl/cu_mod0_1.sv
// cu_mod0_1: FFT stage controller; sequences a frame of N beats then D drain beats,
// emitting registered valid/bf_en/idx/alert one cycle after each beat.
module cu_mod0_1 import fft_ctrl_pkg::*; #(
    parameter int N = N_DEF,
    parameter int D = D_DEF
) (
    input logic        clk,
    input logic        rst,
    cu_mod0_1_if.slave io
);
    localparam int LW = $clog2(N);
    localparam int DW = $clog2(D);
    state_t state_q, state_d;
    logic [LW-1:0] k, idx_q, idx_d;
    logic [DW-1:0] d;
    logic pend_q, pend_d, err_q, err_d, valid_q, valid_d, bf_q, bf_d, alert_q, alert_d;
    logic framing, beat, drain, last_beat, last_drain;
    assign framing    = state_q == ARMED || state_q == RUN;
    assign beat       = framing && io.valid_in;
    assign drain      = state_q == DRAIN;
    assign last_beat  = beat && k == LW'(N - 1);
    assign last_drain = drain && d == DW'(D - 1);
    cnt_en_nb #(.W(LW)) u_beat (.clk(clk), .rst(rst), .en_i(beat), .clr_i(last_beat), .q_o(k));
    cnt_en_nb #(.W(DW)) u_drain (.clk(clk), .rst(rst), .en_i(drain), .clr_i(last_drain), .q_o(d));
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE:  state_d = io.alert_in ? ARMED : IDLE;
            ARMED: state_d = io.valid_in ? RUN : ARMED;
            RUN:   state_d = last_beat ? DRAIN : RUN;
            DRAIN: begin
                pend_d  = last_drain ? 1'b0 : pend_q | io.alert_in;
                state_d = last_drain ? ((pend_q | io.alert_in) ? ARMED : IDLE) : DRAIN;
            end
            default: state_d = IDLE;
        endcase
        err_d   = err_q | (framing & io.alert_in);
        valid_d = beat ? (k >= LW'(D)) : drain;
        bf_d    = beat & k[DW];
        alert_d = beat && k == LW'(D);
        idx_d   = beat ? k : drain ? LW'(d) : idx_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            bf_q    <= 1'b0;
            alert_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            bf_q    <= bf_d;
            alert_q <= alert_d;
            idx_q   <= idx_d;
        end
    assign io.valid_out = valid_q;
    assign io.bf_en     = bf_q;
    assign io.alert_out = alert_q;
    assign io.idx_out   = idx_q;
    assign io.busy      = state_q != IDLE;
    assign io.err       = err_q;
endmodule
